sequence_generator: RTL and testbench

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

---
 rtl/sequence_generator_pkg.sv | 33 +++
 rtl/sequence_generator_lfsr16.sv | 32 +++
 rtl/sequence_generator.sv | 121 ++++++++++++
 tb/tb_sequence_generator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sequence_generator_pkg.sv
// rtl/sequence_generator_pkg.sv - shared constants for the sequence generator
//
// Purpose: FSM state encodings, sequence length, LFSR seed/taps and the
//          per-difficulty maximum digit, plus the difficulty decode helper.
// Ports:   none (package).
package sequence_generator_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int SEQ_LEN = 32;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [3:0] MAX_EASY = 4'd4;
    localparam logic [3:0] MAX_MED  = 4'd6;
    localparam logic [3:0] MAX_HARD = 4'd9;

    // 00 is not a legal difficulty; it falls back to easy.
    function automatic logic [3:0] diff_to_max(input logic [1:0] diff);
        logic [3:0] max_val;
        case (diff)
            2'b10:   max_val = MAX_MED;
            2'b11:   max_val = MAX_HARD;
            default: max_val = MAX_EASY;
        endcase
        return max_val;
    endfunction

endpackage

// File: rtl/sequence_generator_lfsr16.sv
// rtl/sequence_generator_lfsr16.sv - free-running 16-bit Fibonacci LFSR
//
// Purpose: advances every clock from reset release; only reset reloads the seed.
// Ports:   Clk   - clock, rising edge
//          Rst   - asynchronous active-low reset (loads LFSR_SEED)
//          State - current 16-bit LFSR state
module lfsr16
    import sequence_generator_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    output logic [15:0] State
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        feedback;

    assign feedback = ^(state_q & LFSR_TAPS);
    assign state_d  = {state_q[14:0], feedback};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

endmodule

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - fills the sequence RAM with 32 random digits
//
// Purpose: draws candidate digits from an LFSR, keeps those in 1..max for the
//          latched difficulty, and writes them to ascending RAM addresses.
// Ports:   Clk    - clock, rising edge
//          Rst    - asynchronous active-low reset
//          GoGen  - one-cycle (re)generate request
//          Diff   - difficulty (01 easy, 10 medium, 11 hard, 00 = easy)
//          FinGen - sequence RAM holds a complete sequence
//          WrEn   - RAM write strobe, one cycle per digit
//          WrAddr - RAM write address
//          WrData - RAM write data (digit)
module sequence_generator
    import sequence_generator_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       GoGen,
    input  logic [1:0] Diff,
    output logic       FinGen,
    output logic       WrEn,
    output logic [4:0] WrAddr,
    output logic [3:0] WrData
);

    logic [15:0] lfsr_state;
    logic [11:0] lfsr_unused;
    logic [3:0]  candidate;
    logic        accept;

    logic [1:0]  state_q,   state_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [3:0]  max_q,     max_d;
    logic        fin_q,     fin_d;
    logic        wr_en_q,   wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [3:0]  wr_data_q, wr_data_d;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Rst   (Rst),
        .State (lfsr_state)
    );

    assign candidate   = lfsr_state[3:0];
    assign lfsr_unused = lfsr_state[15:4];
    assign accept      = (candidate != 4'd0) && (candidate <= max_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        fin_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (GoGen) begin
                    max_d   = diff_to_max(Diff);
                    cnt_d   = 5'd0;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                // A restart request wins over this cycle's accept decision.
                if (GoGen) begin
                    max_d = diff_to_max(Diff);
                    cnt_d = 5'd0;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = candidate;
                    cnt_d     = cnt_q + 5'd1;
                    if (cnt_q == 5'(SEQ_LEN - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (GoGen) begin
                    max_d   = diff_to_max(Diff);
                    cnt_d   = 5'd0;
                    state_d = ST_GEN;
                end else begin
                    fin_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            max_q     <= MAX_EASY;
            fin_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            fin_q     <= fin_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign FinGen = fin_q;
    assign WrEn   = wr_en_q;
    assign WrAddr = wr_addr_q;
    assign WrData = wr_data_q;

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - directed self-checking bench for sequence_generator
module tb_sequence_generator;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       GoGen = 1'b0;
    logic [1:0] Diff = 2'b01;
    logic       FinGen;
    logic       WrEn;
    logic [4:0] WrAddr;
    logic [3:0] WrData;

    int n_vec = 0;
    int n_err = 0;

    sequence_generator dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .GoGen  (GoGen),
        .Diff   (Diff),
        .FinGen (FinGen),
        .WrEn   (WrEn),
        .WrAddr (WrAddr),
        .WrData (WrData)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_go(input logic [1:0] d);
        Diff  = d;
        GoGen = 1'b1;
        tick();
        GoGen = 1'b0;
    endtask

    // Collects one generation: order, range, count and FinGen timing.
    task automatic gen_run(input string tag, input int maxv, output logic [15:0] seen);
        int  n = 0;
        int  cyc = 0;
        int  last_wr = -100;
        int  fin_cyc = -1;
        bit  order_ok = 1'b1;
        bit  range_ok = 1'b1;
        seen = '0;
        while (fin_cyc < 0 && cyc < 3000) begin
            tick();
            cyc++;
            if (WrEn) begin
                if (WrAddr != 5'(n)) order_ok = 1'b0;
                if (WrData < 4'd1 || int'(WrData) > maxv) range_ok = 1'b0;
                seen[WrData] = 1'b1;
                n++;
                last_wr = cyc;
            end
            if (FinGen) fin_cyc = cyc;
        end
        check({tag, " finished"}, 32'(fin_cyc >= 0), 32'd1);
        check({tag, " write count"}, 32'(n), 32'd32);
        check({tag, " addr order"}, 32'(order_ok), 32'd1);
        check({tag, " data range"}, 32'(range_ok), 32'd1);
        check({tag, " fin delay"}, 32'(fin_cyc - last_wr), 32'd1);
    endtask

    logic [15:0] seen;
    logic [15:0] seen_all;
    int          cnt;
    int          guard;

    initial begin
        // Asynchronous reset before any clock edge
        #1 Rst = 1'b0;
        #1;
        check("rst FinGen", 32'(FinGen), 32'd0);
        check("rst WrEn", 32'(WrEn), 32'd0);
        check("rst WrAddr", 32'(WrAddr), 32'd0);
        check("rst WrData", 32'(WrData), 32'd0);
        check("rst lfsr", 32'(dut.lfsr_state), 32'hACE1);
        #30 Rst = 1'b1;

        // LFSR sequence after release: ACE1 -> 59C3 -> B387 -> 670F
        tick();
        check("lfsr step1", 32'(dut.lfsr_state), 32'h59C3);
        tick();
        check("lfsr step2", 32'(dut.lfsr_state), 32'hB387);
        tick();
        check("lfsr step3", 32'(dut.lfsr_state), 32'h670F);
        check("idle FinGen", 32'(FinGen), 32'd0);
        check("idle WrEn", 32'(WrEn), 32'd0);

        // Easy run
        pulse_go(2'b01);
        gen_run("easy", 4, seen);
        tick();
        tick();
        check("done FinGen held", 32'(FinGen), 32'd1);
        check("done WrEn", 32'(WrEn), 32'd0);

        // Three hard runs via level-up
        seen_all = '0;
        for (int r = 0; r < 3; r++) begin
            pulse_go(2'b11);
            check("levelup FinGen fall", 32'(FinGen), 32'd0);
            gen_run("hard", 9, seen);
            seen_all = seen_all | seen;
        end
        check("hard coverage 1..9", 32'(seen_all[9:1]), 32'h1FF);

        // Diff 00 behaves as easy
        pulse_go(2'b00);
        gen_run("diff00", 4, seen);

        // Abort after address 10, then Diff change must be ignored
        pulse_go(2'b01);
        guard = 0;
        while (!(WrEn && WrAddr == 5'd10) && guard < 2000) begin
            tick();
            guard++;
        end
        check("reach addr10", 32'(guard < 2000), 32'd1);
        Diff  = 2'b01;
        GoGen = 1'b1;
        tick();
        GoGen = 1'b0;
        check("abort no write", 32'(WrEn), 32'd0);
        Diff = 2'b11;
        gen_run("abort", 4, seen);

        // Reset after five writes
        pulse_go(2'b11);
        cnt   = 0;
        guard = 0;
        while (cnt < 5 && guard < 2000) begin
            tick();
            guard++;
            if (WrEn) cnt++;
        end
        check("five writes", 32'(cnt), 32'd5);
        #2 Rst = 1'b0;
        #1;
        check("midrst WrEn", 32'(WrEn), 32'd0);
        check("midrst FinGen", 32'(FinGen), 32'd0);
        check("midrst WrAddr", 32'(WrAddr), 32'd0);
        check("midrst lfsr", 32'(dut.lfsr_state), 32'hACE1);
        @(negedge Clk);
        Rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (WrEn || FinGen) cnt++;
        end
        check("no write after rst", 32'(cnt), 32'd0);

        // Recovery with medium difficulty
        pulse_go(2'b10);
        gen_run("medium", 6, seen);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
